// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// FSM encoding, flush defaults and counter widths.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_FREEZE     = 2'd3
  } hz_state_e;

  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int CNT_W            = 3;
  localparam int STALL_W          = 16;

  function automatic logic [STALL_W-1:0] sat_inc(
    input logic [STALL_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute/memory stage bundle seen by the hazard controller.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3
);
  import hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] i_Rsrc1;
  logic [REG_ADDR_W-1:0] i_Rsrc2;
  logic                  i_use_src1;
  logic                  i_use_src2;
  logic                  i_ex_mem_read;
  logic [REG_ADDR_W-1:0] i_ex_Rdst;
  logic                  i_branch_taken;
  logic                  i_mem_busy;
  logic                  o_pc_en;
  logic                  o_fd_en;
  logic                  o_de_en;
  logic                  o_fd_flush;
  logic                  o_de_bubble;
  logic [STALL_W-1:0]    o_stall_cnt;

  modport master (
    output i_Rsrc1, i_Rsrc2, i_use_src1, i_use_src2,
    output i_ex_mem_read, i_ex_Rdst,
    output i_branch_taken, i_mem_busy,
    input  o_pc_en, o_fd_en, o_de_en,
    input  o_fd_flush, o_de_bubble, o_stall_cnt
  );

  modport slave (
    input  i_Rsrc1, i_Rsrc2, i_use_src1, i_use_src2,
    input  i_ex_mem_read, i_ex_Rdst,
    input  i_branch_taken, i_mem_busy,
    output o_pc_en, o_fd_en, o_de_en,
    output o_fd_flush, o_de_bubble, o_stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator between the decode
// sources and the load sitting in the decode/ALU buffer.
module load_use_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] i_Rsrc1,
  input  logic [REG_ADDR_W-1:0] i_Rsrc2,
  input  logic                  i_use_src1,
  input  logic                  i_use_src2,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_Rdst,
  output logic                  o_hazard
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = i_use_src1 && (i_Rsrc1 == i_ex_Rdst);
  assign w_hit2 = i_use_src2 && (i_Rsrc2 == i_ex_Rdst);
  assign o_hazard = i_ex_mem_read && (w_hit1 || w_hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// memory freeze with state save/resume, stall statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 3,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FL_LOAD =
    CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e          r_state;
  hz_state_e          r_saved;
  logic [CNT_W-1:0]   r_cnt;
  logic [STALL_W-1:0] r_stall_cnt;

  hz_state_e          w_eff;
  hz_state_e          w_next;
  hz_state_e          w_saved_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_hazard;
  logic               w_pc_en;
  logic               w_fd_en;
  logic               w_de_en;
  logic               w_fd_flush;
  logic               w_de_bubble;
  logic               w_stall;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lud (
    .i_Rsrc1       (bus.i_Rsrc1),
    .i_Rsrc2       (bus.i_Rsrc2),
    .i_use_src1    (bus.i_use_src1),
    .i_use_src2    (bus.i_use_src2),
    .i_ex_mem_read (bus.i_ex_mem_read),
    .i_ex_Rdst     (bus.i_ex_Rdst),
    .o_hazard      (w_hazard)
  );

  // A FREEZE cycle whose busy has dropped behaves as the saved state
  always_comb begin
    w_eff = (r_state == ST_FREEZE && !bus.i_mem_busy)
          ? r_saved : r_state;
    w_next      = w_eff;
    w_saved_nxt = r_saved;
    w_cnt_nxt   = r_cnt;
    w_pc_en     = 1'b1;
    w_fd_en     = 1'b1;
    w_de_en     = 1'b1;
    w_fd_flush  = 1'b0;
    w_de_bubble = 1'b0;
    if (bus.i_mem_busy) begin
      w_pc_en = 1'b0;
      w_fd_en = 1'b0;
      w_de_en = 1'b0;
      w_next  = ST_FREEZE;
      if (r_state != ST_FREEZE) w_saved_nxt = r_state;
    end else begin
      unique case (w_eff)
        ST_RUN, ST_LOAD_STALL: begin
          w_next = ST_RUN;
          if (bus.i_branch_taken) begin
            w_fd_flush  = 1'b1;
            w_de_bubble = 1'b1;
            w_cnt_nxt   = FL_LOAD;
            w_next = (FL_LOAD == '0) ? ST_RUN : ST_FLUSH;
          end else if (w_eff == ST_RUN && w_hazard) begin
            w_de_bubble = 1'b1;
            w_pc_en     = 1'b0;
            w_fd_en     = 1'b0;
            w_next      = ST_LOAD_STALL;
          end
        end
        ST_FLUSH: begin
          w_fd_flush  = 1'b1;
          w_de_bubble = 1'b1;
          if (bus.i_branch_taken) begin
            w_cnt_nxt = FL_LOAD;
            w_next = (FL_LOAD == '0) ? ST_RUN : ST_FLUSH;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            w_next = (r_cnt <= CNT_W'(1)) ? ST_RUN : ST_FLUSH;
          end
        end
        default: w_next = ST_RUN;
      endcase
    end
    // Buffers load zero control while reset is held
    if (!rst) begin
      w_pc_en     = 1'b1;
      w_fd_en     = 1'b1;
      w_de_en     = 1'b1;
      w_fd_flush  = 1'b1;
      w_de_bubble = 1'b1;
    end
  end

  assign w_stall = !w_pc_en || w_de_bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_saved     <= ST_RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_saved <= w_saved_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.o_pc_en     = w_pc_en;
  assign bus.o_fd_en     = w_fd_en;
  assign bus.o_de_en     = w_de_en;
  assign bus.o_fd_flush  = w_fd_flush;
  assign bus.o_de_bubble = w_de_bubble;
  assign bus.o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed
// output vectors {pc,fd,de,flush,bubble}.
module tb_hazard_ctrl;

  localparam logic [4:0] RUNO = 5'b11100;
  localparam logic [4:0] STLO = 5'b00101;
  localparam logic [4:0] FLO  = 5'b11111;
  localparam logic [4:0] FRZ  = 5'b00000;
  localparam logic [4:0] RSTO = 5'b11111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [4:0]  outs;

  hazard_ctrl_if #(.REG_ADDR_W(3)) bus ();

  hazard_ctrl #(
    .REG_ADDR_W   (3),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign outs = {bus.o_pc_en, bus.o_fd_en, bus.o_de_en,
                 bus.o_fd_flush, bus.o_de_bubble};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.i_Rsrc1        = '0;
    bus.i_Rsrc2        = '0;
    bus.i_use_src1     = 1'b0;
    bus.i_use_src2     = 1'b0;
    bus.i_ex_mem_read  = 1'b0;
    bus.i_ex_Rdst      = '0;
    bus.i_branch_taken = 1'b0;
    bus.i_mem_busy     = 1'b0;
  endtask

  task automatic set_hz(input logic [2:0] s1, input logic [2:0] s2,
                        input logic u1, input logic u2,
                        input logic rd, input logic [2:0] dst);
    bus.i_Rsrc1       = s1;
    bus.i_Rsrc2       = s2;
    bus.i_use_src1    = u1;
    bus.i_use_src2    = u2;
    bus.i_ex_mem_read = rd;
    bus.i_ex_Rdst     = dst;
  endtask

  task automatic test_reset();
    clear_in();
    #2;
    if (outs !== RSTO) begin
      $display("FAIL reset_outs got=%b want=%b", outs, RSTO);
      errors++;
    end
    checks++;
    if (bus.o_stall_cnt !== 16'd0) begin
      $display("FAIL reset_cnt got=%0d want=0", bus.o_stall_cnt);
      errors++;
    end
    checks++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (outs !== RUNO) begin
      $display("FAIL release_outs got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    tick();
    if (bus.o_stall_cnt !== 16'd0) begin
      $display("FAIL release_cnt got=%0d want=0", bus.o_stall_cnt);
      errors++;
    end
    checks++;
  endtask

  task automatic test_no_hazard();
    set_hz(3'd3, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3);
    #1;
    if (outs !== RUNO) begin
      $display("FAIL nohz_flags0 got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    tick();
    set_hz(3'd2, 3'd5, 1'b1, 1'b1, 1'b1, 3'd3);
    #1;
    if (outs !== RUNO) begin
      $display("FAIL nohz_mismatch got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    tick();
    set_hz(3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3);
    #1;
    if (outs !== RUNO) begin
      $display("FAIL nohz_noload got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    tick();
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL nohz_cnt got=%0d want=%0d",
               bus.o_stall_cnt, exp_cnt);
      errors++;
    end
    checks++;
    clear_in();
  endtask

  task automatic test_load_use();
    set_hz(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3);
    #1;
    if (outs !== STLO) begin
      $display("FAIL lu_src1 got=%b want=%b", outs, STLO);
      errors++;
    end
    checks++;
    tick();
    exp_cnt++;
    if (outs !== RUNO) begin
      $display("FAIL lu_stall_state got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL lu_cnt got=%0d want=%0d",
               bus.o_stall_cnt, exp_cnt);
      errors++;
    end
    checks++;
    clear_in();
    tick();
    if (outs !== RUNO) begin
      $display("FAIL lu_back_run got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    set_hz(3'd1, 3'd7, 1'b0, 1'b1, 1'b1, 3'd7);
    #1;
    if (outs !== STLO) begin
      $display("FAIL lu_src2 got=%b want=%b", outs, STLO);
      errors++;
    end
    checks++;
    tick();
    exp_cnt++;
    clear_in();
    tick();
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL lu_src2_cnt got=%0d want=%0d",
               bus.o_stall_cnt, exp_cnt);
      errors++;
    end
    checks++;
  endtask

  task automatic test_branch();
    bus.i_branch_taken = 1'b1;
    #1;
    if (outs !== FLO) begin
      $display("FAIL br_c0 got=%b want=%b", outs, FLO);
      errors++;
    end
    checks++;
    tick();
    bus.i_branch_taken = 1'b0;
    #1;
    if (outs !== FLO) begin
      $display("FAIL br_c1 got=%b want=%b", outs, FLO);
      errors++;
    end
    checks++;
    tick();
    exp_cnt += 16'd2;
    if (outs !== RUNO) begin
      $display("FAIL br_end got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL br_cnt got=%0d want=%0d",
               bus.o_stall_cnt, exp_cnt);
      errors++;
    end
    checks++;
  endtask

  task automatic test_branch_hazard();
    set_hz(3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4);
    bus.i_branch_taken = 1'b1;
    #1;
    if (outs !== FLO) begin
      $display("FAIL brhz_c0 got=%b want=%b", outs, FLO);
      errors++;
    end
    checks++;
    tick();
    bus.i_branch_taken = 1'b0;
    #1;
    if (outs !== FLO) begin
      $display("FAIL brhz_c1 got=%b want=%b", outs, FLO);
      errors++;
    end
    checks++;
    tick();
    clear_in();
    #1;
    exp_cnt += 16'd2;
    if (outs !== RUNO) begin
      $display("FAIL brhz_end got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_branch_restart();
    bus.i_branch_taken = 1'b1;
    tick();
    #1;
    if (outs !== FLO) begin
      $display("FAIL brrs_c1 got=%b want=%b", outs, FLO);
      errors++;
    end
    checks++;
    tick();
    bus.i_branch_taken = 1'b0;
    #1;
    if (outs !== FLO) begin
      $display("FAIL brrs_c2 got=%b want=%b", outs, FLO);
      errors++;
    end
    checks++;
    tick();
    exp_cnt += 16'd3;
    if (outs !== RUNO) begin
      $display("FAIL brrs_end got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
  endtask

  task automatic test_freeze();
    bus.i_branch_taken = 1'b1;
    tick();
    bus.i_branch_taken = 1'b0;
    bus.i_mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (outs !== FRZ) begin
        $display("FAIL frz_c%0d got=%b want=%b", i, outs, FRZ);
        errors++;
      end
      checks++;
      tick();
    end
    bus.i_mem_busy = 1'b0;
    #1;
    if (outs !== FLO) begin
      $display("FAIL frz_resume got=%b want=%b", outs, FLO);
      errors++;
    end
    checks++;
    tick();
    exp_cnt += 16'd5;
    if (outs !== RUNO) begin
      $display("FAIL frz_end got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL frz_cnt got=%0d want=%0d",
               bus.o_stall_cnt, exp_cnt);
      errors++;
    end
    checks++;
    bus.i_mem_busy     = 1'b1;
    bus.i_branch_taken = 1'b1;
    #1;
    if (outs !== FRZ) begin
      $display("FAIL frz_prio got=%b want=%b", outs, FRZ);
      errors++;
    end
    checks++;
    tick();
    clear_in();
    #1;
    if (outs !== RUNO) begin
      $display("FAIL frz_run_resume got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    tick();
    exp_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.i_branch_taken = 1'b1;
    tick();
    bus.i_branch_taken = 1'b0;
    rst = 1'b0;
    #1;
    if (outs !== RSTO) begin
      $display("FAIL rstm_outs got=%b want=%b", outs, RSTO);
      errors++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    exp_cnt = 16'd0;
    if (outs !== RUNO) begin
      $display("FAIL rstm_run got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL rstm_cnt got=%0d want=0", bus.o_stall_cnt);
      errors++;
    end
    checks++;
    bus.i_mem_busy = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    if (outs !== RUNO) begin
      $display("FAIL rstf_run got=%b want=%b", outs, RUNO);
      errors++;
    end
    checks++;
    if (bus.o_stall_cnt !== 16'd0) begin
      $display("FAIL rstf_cnt got=%0d want=0", bus.o_stall_cnt);
      errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_load_use();
    test_branch();
    test_branch_hazard();
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL brhz_cnt got=%0d want=%0d",
               bus.o_stall_cnt, exp_cnt);
      errors++;
    end
    checks++;
    test_branch_restart();
    test_freeze();
    if (bus.o_stall_cnt !== exp_cnt) begin
      $display("FAIL frz_total_cnt got=%0d want=%0d",
               bus.o_stall_cnt, exp_cnt);
      errors++;
    end
    checks++;
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
